// File: rtl/irrigation_scheduler.sv
// Tank/irrigation controller: synced+debounced sensors, timed spray/drip/rest FSM.
// Optional FILL_TIMEOUT_EN adds a Ve on-time watchdog that forces FAULT.
module irrigation_scheduler #(
  parameter int TW        = 16,
  parameter int DEB_CYC   = 4,
  parameter int SPRAY_MAX = 1000,
  parameter int DRIP_MAX  = 2000,
  parameter int REST_CYC  = 500,
  parameter int FILL_MAX  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       L,
  input  logic       M,
  input  logic       H,
  input  logic       Us,
  input  logic       Ua,
  input  logic       T,
  input  logic       Clr,
  output logic       Ve,
  output logic       Vs,
  output logic       Bs,
  output logic       Al,
  output logic       Error,
  output logic [1:0] Lvl,
  output logic [2:0] St
);

  localparam int DW = $clog2(DEB_CYC + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPRAY = 3'd1;
  localparam logic [2:0] S_DRIP  = 3'd2;
  localparam logic [2:0] S_REST  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [5:0]    w_raw;
  logic [5:0]    r_s1;
  logic [5:0]    r_s2;
  logic [5:0]    r_deb;
  logic [DW-1:0] r_dcnt [6];
  logic [1:0]    r_lvl;
  logic [2:0]    r_st;
  logic [TW-1:0] r_tmr;
  logic          r_fill;
  logic          r_vs;
  logic          r_bs;
  logic          r_al;
  logic          r_err;

  logic          w_lvl_bad;
  logic [1:0]    w_lvl_dec;
  logic          w_us;
  logic          w_ua;
  logic          w_t;
  logic          w_want_spray;
  logic          w_want_drip;
  logic          w_fto;
  logic          w_flt;
  logic [2:0]    w_nxt;
  logic [TW-1:0] w_tmr;

  assign w_raw = {T, Ua, Us, H, M, L};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Any cycle where the synced value matches the accepted one restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb <= '0;
      for (int i = 0; i < 6; i++) r_dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DW'(DEB_CYC - 1)) begin
          r_deb[i]  <= r_s2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_lvl_bad = 1'b0;
    w_lvl_dec = r_lvl;
    case (r_deb[2:0])
      3'b000:  w_lvl_dec = 2'd0;
      3'b001:  w_lvl_dec = 2'd1;
      3'b011:  w_lvl_dec = 2'd2;
      3'b111:  w_lvl_dec = 2'd3;
      default: w_lvl_bad = 1'b1;
    endcase
  end

  assign w_us = r_deb[3];
  assign w_ua = r_deb[4];
  assign w_t  = r_deb[5];

  assign w_want_spray = !w_us & ((r_lvl == 2'd2) | ((r_lvl == 2'd3) & !w_t));
  assign w_want_drip  = w_ua & !w_us & (r_lvl != 2'd0) & ((r_lvl == 2'd1) | w_t);

`ifdef FILL_TIMEOUT_EN
  logic [TW-1:0] r_fcnt;

  always_ff @(posedge clk) begin
    if (rst || !r_fill) r_fcnt <= '0;
    else                r_fcnt <= r_fcnt + 1'b1;
  end

  assign w_fto = r_fill & (r_fcnt == TW'(FILL_MAX - 1));
`else
  assign w_fto = 1'b0;
`endif

  assign w_flt = w_lvl_bad | w_fto;

  always_comb begin
    w_nxt = r_st;
    w_tmr = '0;
    case (r_st)
      S_IDLE: begin
        if (w_flt) begin
          w_nxt = S_FAULT;
        end else if (w_want_spray) begin
          w_nxt = S_SPRAY;
          w_tmr = TW'(SPRAY_MAX - 1);
        end else if (w_want_drip) begin
          w_nxt = S_DRIP;
          w_tmr = TW'(DRIP_MAX - 1);
        end
      end
      S_SPRAY: begin
        if (w_flt) begin
          w_nxt = S_FAULT;
        end else if (w_us || r_lvl <= 2'd1 || r_tmr == '0) begin
          w_nxt = S_REST;
          w_tmr = TW'(REST_CYC - 1);
        end else begin
          w_tmr = r_tmr - 1'b1;
        end
      end
      S_DRIP: begin
        if (w_flt) begin
          w_nxt = S_FAULT;
        end else if (w_us || r_lvl == 2'd0 || r_tmr == '0) begin
          w_nxt = S_REST;
          w_tmr = TW'(REST_CYC - 1);
        end else begin
          w_tmr = r_tmr - 1'b1;
        end
      end
      S_REST: begin
        if (w_flt)              w_nxt = S_FAULT;
        else if (r_tmr == '0)   w_nxt = S_IDLE;
        else                    w_tmr = r_tmr - 1'b1;
      end
      S_FAULT: begin
        if (Clr && !w_lvl_bad) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track St exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= S_IDLE;
      r_tmr  <= '0;
      r_lvl  <= 2'd0;
      r_fill <= 1'b0;
      r_vs   <= 1'b0;
      r_bs   <= 1'b0;
      r_al   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_st  <= w_nxt;
      r_tmr <= w_tmr;
      if (!w_lvl_bad) r_lvl <= w_lvl_dec;
      if (r_lvl == 2'd3 || w_nxt == S_FAULT) r_fill <= 1'b0;
      else if (r_lvl <= 2'd1)                r_fill <= 1'b1;
      r_vs  <= (w_nxt == S_DRIP);
      r_bs  <= (w_nxt == S_SPRAY);
      r_err <= (w_nxt == S_FAULT);
      r_al  <= (w_nxt == S_FAULT) | (r_lvl <= 2'd1);
    end
  end

  assign Ve    = r_fill;
  assign Vs    = r_vs;
  assign Bs    = r_bs;
  assign Al    = r_al;
  assign Error = r_err;
  assign Lvl   = r_lvl;
  assign St    = r_st;

endmodule
